// File: rtl/counter_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : counter_seq_ctrl
//  Brief    : Sequences an external up-counter through timed intervals of
//             LIMIT+1 counts (one-shot or periodic) with pause and abort.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
   parameter int SIZE = 8
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic            START,
   input  logic            STOP,
   input  logic            PAUSE,
   input  logic            MODE,
   input  logic [SIZE-1:0] LIMIT,
   input  logic [SIZE-1:0] CNT_Q,
   output logic            CNT_CE,
   output logic            CNT_SR,
   output logic            BUSY,
   output logic            DONE,
   output logic [SIZE-1:0] PERIODS
);

   localparam logic [SIZE-1:0] PERIODS_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            done_q, done_d;
   logic [SIZE-1:0] periods_q, periods_d;
   logic [SIZE-1:0] limit_q, limit_d;
   logic            mode_q, mode_d;
   logic            term;

   // Unsigned >= so a counter disturbed past the limit still terminates.
   assign term = (CNT_Q >= limit_q);

   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      periods_d = periods_q;
      limit_d   = limit_q;
      mode_d    = mode_q;
      CNT_CE    = 1'b0;
      CNT_SR    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START && !STOP) begin
               limit_d   = LIMIT;
               mode_d    = MODE;
               periods_d = '0;
               state_d   = S_CLEAR;
            end
         end
         S_CLEAR: begin
            CNT_SR  = 1'b1;
            state_d = STOP ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            if (STOP) begin
               CNT_SR  = 1'b1;
               state_d = S_IDLE;
            end else if (PAUSE) begin
               state_d = S_RUN;
            end else if (term) begin
               done_d = 1'b1;
               if (periods_q != PERIODS_MAX) begin
                  periods_d = periods_q + 1'b1;
               end
               state_d = mode_q ? S_CLEAR : S_IDLE;
            end else begin
               CNT_CE = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= S_IDLE;
         done_q    <= 1'b0;
         periods_q <= '0;
         limit_q   <= '0;
         mode_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         periods_q <= periods_d;
         limit_q   <= limit_d;
         mode_q    <= mode_d;
      end
   end

   assign BUSY    = (state_q != S_IDLE);
   assign DONE    = done_q;
   assign PERIODS = periods_q;

endmodule
`default_nettype wire
